bin2bcd_seg_feed: RTL and testbench

- Producer side of the 6-digit seven-segment display interface: the block that drives the display driver's `data[23:0]` and `en` inputs.
- Converts an unsigned binary count into six packed BCD digits, using a sequential shift-add-3 (double-dabble) engine.
- Holds the converted result stable for the multiplexed display driver, and qualifies it with `en`.
- Sits between application counters/timers and the display driver.

---
 rtl/bin2bcd_seg_feed.sv | 182 ++++++++++++++++++
 tb/tb_bin2bcd_seg_feed.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seg_feed.sv
// bin2bcd_seg_feed: converts an unsigned binary count into six packed BCD
// digits with a sequential shift-add-3 engine. It holds the result stable for
// a multiplexed seven-segment driver and qualifies it with en.
//
// Handshake: start is a single-cycle request. It is accepted only in IDLE;
// while busy=1 it is ignored and bin_in is not resampled. done pulses for
// exactly one cycle, in the same cycle that data/ovf take their new values.
//
// Optional feature: define AUTO_REFRESH_EN to add a free-running counter
// that issues an internal start every REFRESH_CYCLES clocks.
module bin2bcd_seg_feed #(
   parameter int BIN_W          = 20,
   parameter int REFRESH_CYCLES = 50_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BIN_W-1:0] bin_in,
   input  logic             start,
   input  logic             disp_on,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [23:0]      data,
   output logic             en
);

   // Elaboration-time guards on the parameter ranges.
   if (BIN_W < 1 || BIN_W > 20) begin : g_bad_bin_w
      $error("bin2bcd_seg_feed: BIN_W must be in 1..20");
   end
   if (REFRESH_CYCLES < 1) begin : g_bad_refresh
      $error("bin2bcd_seg_feed: REFRESH_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } state_e;

   localparam logic [4:0] LAST_IT = 5'(BIN_W - 1);

   state_e           state_q, state_d;
   logic [BIN_W-1:0] sh_q, sh_d;
   logic [23:0]      scr_q, scr_d;
   logic [23:0]      scr_adj;
   logic [4:0]       cnt_q, cnt_d;
   logic             over_q, over_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic [23:0]      data_q, data_d;
   logic             valid_q, valid_d;
   logic             en_q, en_d;
   logic [19:0]      bin_ext;
   logic             in_over;
   logic             start_any;

`ifdef AUTO_REFRESH_EN
   localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

   logic [RW-1:0] ref_q, ref_d;
   logic          auto_start;

   // Free-running refresh counter 0..REFRESH_CYCLES-1; the wrap requests a conversion.
   always_comb begin
      auto_start = (ref_q == REF_LAST);
      ref_d      = auto_start ? '0 : ref_q + RW'(1);
   end

   // Refresh counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ref_q <= '0;
      else        ref_q <= ref_d;
   end

   assign start_any = start | auto_start;
`else
   assign start_any = start;
`endif

   // Saturation only matters at full width: 19 bits cannot exceed 999999.
   always_comb begin
      bin_ext              = '0;
      bin_ext[BIN_W-1:0]   = bin_in;
      in_over              = (BIN_W == 20) && (bin_ext > 20'd999_999);
   end

   // Add 3 to every scratch nibble that is 5 or more, ahead of the shift.
   always_comb begin
      scr_adj = scr_q;
      for (int i = 0; i < 6; i++) begin
         if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
   end

   // FSM next-state and datapath updates; done is a pulse so it defaults low.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      over_d  = over_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      data_d  = data_q;
      valid_d = valid_q;
      en_d    = disp_on & valid_q;
      case (state_q)
         IDLE: begin
            if (start_any) begin
               state_d = SHIFT;
               sh_d    = bin_in;
               scr_d   = '0;
               cnt_d   = '0;
               over_d  = in_over;
               busy_d  = 1'b1;
            end
         end
         SHIFT: begin
            {scr_d, sh_d} = {scr_adj, sh_q} << 1;
            cnt_d         = cnt_q + 5'd1;
            if (cnt_q == LAST_IT) state_d = LOAD;
         end
         LOAD: begin
            if (over_q) begin
               data_d = 24'h999999;
               ovf_d  = 1'b1;
            end else begin
               data_d = scr_q;
               ovf_d  = 1'b0;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any conversion without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sh_q    <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         over_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         over_q  <= over_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         en_q    <= en_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign ovf  = ovf_q;
   assign data = data_q;
   assign en   = en_q;

endmodule

// File: tb/tb_bin2bcd_seg_feed.sv
// Testbench for bin2bcd_seg_feed: randomized and directed conversions checked
// against an arithmetic decimal-digit reference model.
module tb_bin2bcd_seg_feed;

   localparam int BW  = 20;
   localparam int LAT = BW + 1;
`ifdef AUTO_REFRESH_EN
   localparam int REF_CYC = 100;
`else
   localparam int REF_CYC = 50_000_000;
`endif

   logic          clk;
   logic          rst_n;
   logic [BW-1:0] bin_in;
   logic          start;
   logic          disp_on;
   logic          busy;
   logic          done;
   logic          ovf;
   logic [23:0]   data;
   logic          en;

   int n_cmp;
   int n_err;

   bin2bcd_seg_feed #(
      .BIN_W          (BW),
      .REFRESH_CYCLES (REF_CYC)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bin_in  (bin_in),
      .start   (start),
      .disp_on (disp_on),
      .busy    (busy),
      .done    (done),
      .ovf     (ovf),
      .data    (data),
      .en      (en)
   );

   // Clock: 50 MHz.
   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Single checking task; every comparison goes through here.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: saturate to 999999 and split into decimal digits.
   function automatic logic [23:0] ref_bcd(input int unsigned v);
      int unsigned x;
      logic [23:0] r;
      x = (v > 999_999) ? 999_999 : v;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic ref_ovf(input int unsigned v);
      return v > 999_999;
   endfunction

   task automatic apply_reset();
      rst_n   = 1'b0;
      start   = 1'b0;
      bin_in  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Convert v starting at a negedge; optionally fire an extra start (to be
   // ignored) inj_k cycles into the conversion. Returns at the done negedge.
   task automatic run_conv(input int unsigned v, input int inj_k, input int unsigned inj_v);
      int k;
      bin_in = BW'(v);
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done && k < 3 * LAT) begin
         check("busy_during_conv", busy, 1'b1);
         if (k == inj_k) begin
            bin_in = BW'(inj_v);
            start  = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
         k++;
      end
      check("done_latency", k, LAT);
      check("busy_at_done", busy, 1'b0);
      check("data", data, ref_bcd(v));
      check("ovf", ovf, ref_ovf(v));
   endtask

   // Count done pulses over n cycles; expect none.
   task automatic expect_quiet(input string tag, input int n);
      int cnt;
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check(tag, cnt, 0);
   endtask

   initial begin
      int unsigned v;
      logic        d;
      logic [23:0] held;
      int          e;
      n_cmp   = 0;
      n_err   = 0;
      disp_on = 1'b0;
      apply_reset();
`ifdef AUTO_REFRESH_EN
      // First automatic conversion starts REF_CYC edges after release.
      e = 0;
      while (!done && e < 4 * REF_CYC) begin
         @(negedge clk);
         e++;
      end
      check("auto_first_done", e, REF_CYC + LAT);
      e = 0;
      @(negedge clk);
      e++;
      while (!done && e < 4 * REF_CYC) begin
         @(negedge clk);
         e++;
      end
      check("auto_period", e, REF_CYC);
      check("auto_data", data, 24'h000000);
`else
      // Reset state.
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_data", data, 24'h0);
      check("rst_en", en, 1'b0);

      // Display enable before any conversion stays off.
      disp_on = 1'b1;
      repeat (3) @(negedge clk);
      check("en_before_valid", en, 1'b0);

      // First conversion; en rises one cycle after done.
      run_conv(123456, -1, 0);
      check("en_at_first_done", en, 1'b0);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("en_after_done", en, 1'b1);

      // Boundary values.
      run_conv(0, -1, 0);
      run_conv(999_999, -1, 0);
      run_conv(1_000_000, -1, 0);
      run_conv(42, -1, 0);
      run_conv(20'hFFFFF, -1, 0);

      // Start while busy is ignored; start in the done cycle is accepted.
      @(negedge clk);
      run_conv(111111, 5, 222222);
      run_conv(333333, -1, 0);
      expect_quiet("no_queued_start", 3 * LAT);
      check("data_after_ignore", data, 24'h333333);

      // Disabling the display drops en but keeps data.
      held    = data;
      disp_on = 1'b0;
      @(negedge clk);
      check("en_off", en, 1'b0);
      check("data_held", data, held);

      // Randomized conversions with en tracking disp_on.
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0) v = $urandom_range(999_990, 20'hFFFFF);
         else                           v = $urandom_range(0, 999_999);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_conv(v, (($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 19)) : -1),
                  $urandom_range(0, 999_999));
         d       = 1'($urandom_range(0, 1));
         disp_on = d;
         @(negedge clk);
         check("en_follow", en, d);
      end

      // Reset mid-conversion aborts with all outputs cleared and no done.
      disp_on = 1'b1;
      bin_in  = BW'(777777);
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_ovf", ovf, 1'b0);
      check("abort_data", data, 24'h0);
      check("abort_en", en, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expect_quiet("abort_no_done", 2 * LAT);
      check("abort_valid_cleared_en", en, 1'b0);
      run_conv(654321, -1, 0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
